// File: rtl/fp_conv_arbiter.sv
// -----------------------------------------------------------------------------
// fp_conv_arbiter
//
// Shares one float-to-integer converter among NUM_REQ requesters. A
// round-robin arbiter picks one requester in IDLE. The design latches that
// requester's operand and rounding mode, then starts the converter. It waits
// for completion and holds the result until the consumer accepts it. Only one
// conversion is in flight at a time.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   PRECISION  float operand width
//   INT_SIZE   integer result width
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   req            per-requester request level
//   float_in       packed operands, requester i at slice i
//   conv_in        packed 2-bit rounding modes, requester i at slice i
//   gnt            one-hot, one-cycle grant pulse (operand captured that cycle)
//   rsp_valid      result valid, held until rsp_ready
//   rsp_ready      result accepted
//   rsp_id         index of the requester owning the result
//   rsp_int        converted integer
//   rsp_invalid    invalid-operation flag of the result
//   cv_start       one-cycle start pulse to the converter
//   cv_float       operand presented to the converter
//   cv_conv        rounding mode presented to the converter
//   cv_done        converter completion (level, only honoured in WAIT)
//   cv_int         converter result
//   cv_invalid     converter invalid flag
//
// Build option
//   FP_CONV_ARB_TIMEOUT_EN  when defined, a 6-bit watchdog runs in WAIT. After
//                           64 cycles with no cv_done, the design forces an
//                           invalid response with only the MSB of rsp_int set.
//                           When undefined, WAIT lasts until cv_done.
// -----------------------------------------------------------------------------
module fp_conv_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int PRECISION = 32,
   parameter int INT_SIZE  = 64,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*PRECISION-1:0]  float_in,
   input  logic [NUM_REQ*2-1:0]          conv_in,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [INT_SIZE-1:0]           rsp_int,
   output logic                          rsp_invalid,
   output logic                          cv_start,
   output logic [PRECISION-1:0]          cv_float,
   output logic [1:0]                    cv_conv,
   input  logic                          cv_done,
   input  logic [INT_SIZE-1:0]           cv_int,
   input  logic                          cv_invalid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;

   logic                   arm_r;
   logic [ID_W-1:0]        ptr_r;
   logic                   win_vld_s;
   logic [ID_W-1:0]        win_id_s;
   logic                   grant_s;
   logic [NUM_REQ-1:0]     gnt_s;
   logic [PRECISION-1:0]   sel_float_s;
   logic [1:0]             sel_conv_s;
   logic                   tmo_hit_s;

   logic                   cv_start_r;
   logic [PRECISION-1:0]   cv_float_r;
   logic [1:0]             cv_conv_r;
   logic                   rsp_valid_r;
   logic [ID_W-1:0]        rsp_id_r;
   logic [INT_SIZE-1:0]    rsp_int_r;
   logic                   rsp_invalid_r;

   // Requester index reached by stepping offs places above base, with wrap.
   function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                input int offs);
      return ID_W'((int'(base) + offs) % NUM_REQ);
   endfunction

   // Round-robin search from ptr+1 upward. The scan runs from the farthest
   // candidate to the nearest, so the nearest active requester is written last.
   always_comb begin
      win_vld_s = 1'b0;
      win_id_s  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[rr_index(ptr_r, k)]) begin
            win_vld_s = 1'b1;
            win_id_s  = rr_index(ptr_r, k);
         end else begin
            win_vld_s = win_vld_s;
            win_id_s  = win_id_s;
         end
      end
   end

   // A grant happens only in IDLE, and only once the first clock after reset
   // has passed. This keeps gnt low while reset is held.
   assign grant_s = (state_r == IDLE) && arm_r && win_vld_s;

   // The grant pulse is decoded in the cycle the operand is latched.
   always_comb begin
      gnt_s = '0;
      if (grant_s) begin
         gnt_s[win_id_s] = 1'b1;
      end else begin
         gnt_s = '0;
      end
   end

   // Operand and rounding-mode mux for the winning requester.
   always_comb begin
      sel_float_s = '0;
      sel_conv_s  = 2'b00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id_s == ID_W'(i)) begin
            sel_float_s = float_in[i*PRECISION +: PRECISION];
            sel_conv_s  = conv_in[i*2 +: 2];
         end else begin
            sel_float_s = sel_float_s;
            sel_conv_s  = sel_conv_s;
         end
      end
   end

`ifdef FP_CONV_ARB_TIMEOUT_EN
   logic [5:0] tmo_cnt_r;

   // Watchdog counter: counts cycles spent in WAIT and clears elsewhere.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_r <= 6'd0;
      end else if (state_r == WAIT) begin
         tmo_cnt_r <= tmo_cnt_r + 6'd1;
      end else begin
         tmo_cnt_r <= 6'd0;
      end
   end

   // The 64th WAIT cycle without completion is the last one.
   assign tmo_hit_s = (tmo_cnt_r == 6'd63);
`else
   assign tmo_hit_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic. cv_done counts only in WAIT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            state_nxt_s = WAIT;
         end
         WAIT: begin
            if (cv_done || tmo_hit_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Arbitration pointer, grant qualifier and the captured request context.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arm_r      <= 1'b0;
         ptr_r      <= ID_W'(NUM_REQ - 1);
         rsp_id_r   <= '0;
         cv_float_r <= '0;
         cv_conv_r  <= 2'b00;
      end else begin
         arm_r <= 1'b1;
         if (grant_s) begin
            ptr_r      <= win_id_s;
            rsp_id_r   <= win_id_s;
            cv_float_r <= sel_float_s;
            cv_conv_r  <= sel_conv_s;
         end else begin
            ptr_r      <= ptr_r;
            rsp_id_r   <= rsp_id_r;
            cv_float_r <= cv_float_r;
            cv_conv_r  <= cv_conv_r;
         end
      end
   end

   // State-following strobes are registered from the next state. They are
   // high exactly while the FSM sits in ISSUE or RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cv_start_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         cv_start_r  <= (state_nxt_s == ISSUE);
         rsp_valid_r <= (state_nxt_s == RESP);
      end
   end

   // Result capture: the converter result on completion, or the forced
   // invalid pattern when the watchdog expires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_int_r     <= '0;
         rsp_invalid_r <= 1'b0;
      end else if ((state_r == WAIT) && cv_done) begin
         rsp_int_r     <= cv_int;
         rsp_invalid_r <= cv_invalid;
      end else if ((state_r == WAIT) && tmo_hit_s) begin
         rsp_int_r     <= {1'b1, {(INT_SIZE-1){1'b0}}};
         rsp_invalid_r <= 1'b1;
      end else begin
         rsp_int_r     <= rsp_int_r;
         rsp_invalid_r <= rsp_invalid_r;
      end
   end

   assign gnt         = gnt_s;
   assign cv_start    = cv_start_r;
   assign cv_float    = cv_float_r;
   assign cv_conv     = cv_conv_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_id      = rsp_id_r;
   assign rsp_int     = rsp_int_r;
   assign rsp_invalid = rsp_invalid_r;

endmodule

// File: tb/tb_fp_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_conv_arbiter
//
// Directed bench for fp_conv_arbiter with the default parameters. Inputs are
// driven 1 time unit after the rising edge. Outputs are sampled on the
// falling edge. The bench plays the converter by driving cv_done, cv_int and
// cv_invalid by hand.
// -----------------------------------------------------------------------------
module tb_fp_conv_arbiter;

   localparam logic [31:0] F0 = 32'h4049_0FDB;
   localparam logic [31:0] F1 = 32'h3F80_0000;
   localparam logic [31:0] F2 = 32'h4040_0000;
   localparam logic [31:0] F3 = 32'h4120_0000;

   logic          clk;
   logic          reset;
   logic [3:0]    req;
   logic [127:0]  float_in;
   logic [7:0]    conv_in;
   logic [3:0]    gnt;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [63:0]   rsp_int;
   logic          rsp_invalid;
   logic          cv_start;
   logic [31:0]   cv_float;
   logic [1:0]    cv_conv;
   logic          cv_done;
   logic [63:0]   cv_int;
   logic          cv_invalid;

   int n_cmp;
   int n_err;
   int stray;

   fp_conv_arbiter #(.NUM_REQ(4), .PRECISION(32), .INT_SIZE(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .float_in    (float_in),
      .conv_in     (conv_in),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_int     (rsp_int),
      .rsp_invalid (rsp_invalid),
      .cv_start    (cv_start),
      .cv_float    (cv_float),
      .cv_conv     (cv_conv),
      .cv_done     (cv_done),
      .cv_int      (cv_int),
      .cv_invalid  (cv_invalid)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d compared", n_cmp);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // One full conversion starting in an IDLE cycle, with minimum latency.
   task automatic run_conv(input string tag, input logic [3:0] r, input logic drop,
                           input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input logic [31:0] exp_float, input logic [1:0] exp_conv,
                           input logic [63:0] res, input logic inv);
      cyc(); req = r;
      smp(); chk({tag, "_gnt"}, gnt, exp_gnt);
             chk({tag, "_nostart"}, cv_start, 1'b0);
      cyc(); if (drop) req = 4'b0000;
      smp(); chk({tag, "_start"}, cv_start, 1'b1);
             chk({tag, "_gnt_issue"}, gnt, 4'b0000);
             chk({tag, "_float"}, cv_float, exp_float);
             chk({tag, "_conv"}, cv_conv, exp_conv);
      cyc(); cv_done = 1'b1; cv_int = res; cv_invalid = inv;
      smp(); chk({tag, "_start_low"}, cv_start, 1'b0);
             chk({tag, "_vld_early"}, rsp_valid, 1'b0);
      cyc(); cv_done = 1'b0; cv_int = 64'd0; cv_invalid = 1'b0;
      smp(); chk({tag, "_vld"}, rsp_valid, 1'b1);
             chk({tag, "_id"}, rsp_id, exp_id);
             chk({tag, "_int"}, rsp_int, res);
             chk({tag, "_inv"}, rsp_invalid, inv);
             chk({tag, "_gnt_resp"}, gnt, 4'b0000);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      req = 4'b1111;
      float_in = {F3, F2, F1, F0};
      conv_in = {2'b00, 2'b11, 2'b10, 2'b01};
      rsp_ready = 1'b1;
      cv_done = 1'b0;
      cv_int = 64'd0;
      cv_invalid = 1'b0;

      // Reset state, with every request held high.
      repeat (2) @(posedge clk);
      smp();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_start", cv_start, 1'b0);
      chk("rst_vld", rsp_valid, 1'b0);
      chk("rst_id", rsp_id, 2'd0);
      chk("rst_int", rsp_int, 64'd0);
      chk("rst_inv", rsp_invalid, 1'b0);
      chk("rst_float", cv_float, 32'd0);
      chk("rst_conv", cv_conv, 2'd0);
      cyc(); reset = 1'b1; req = 4'b0000;
      smp();

      // Single request; req dropped after grant must not cancel.
      run_conv("single", 4'b0001, 1'b1, 4'b0001, 2'd0, F0, 2'b01, 64'd3, 1'b0);

      // Fairness from a fresh reset: 0,1,2,3 then 0 with all requests held.
      cyc(); reset = 1'b0;
      smp(); chk("rst2_vld", rsp_valid, 1'b0);
      cyc(); reset = 1'b1;
      smp();
      run_conv("rr0", 4'b1111, 1'b0, 4'b0001, 2'd0, F0, 2'b01, 64'd100, 1'b0);
      run_conv("rr1", 4'b1111, 1'b0, 4'b0010, 2'd1, F1, 2'b10, 64'd101, 1'b0);
      run_conv("rr2", 4'b1111, 1'b0, 4'b0100, 2'd2, F2, 2'b11, 64'd102, 1'b0);
      run_conv("rr3", 4'b1111, 1'b0, 4'b1000, 2'd3, F3, 2'b00, 64'd103, 1'b0);
      run_conv("rr4", 4'b1111, 1'b0, 4'b0001, 2'd0, F0, 2'b01, 64'd104, 1'b0);

      // Backpressure: rsp_ready low for 5 RESP cycles.
      cyc();
      smp(); chk("bp_gnt", gnt, 4'b0010);
      cyc();
      smp();
      cyc(); cv_done = 1'b1; cv_int = 64'h0123_4567_89AB_CDEF; rsp_ready = 1'b0;
      smp();
      cyc(); cv_done = 1'b0; cv_int = 64'd0;
      smp(); chk("bp_vld0", rsp_valid, 1'b1);
             chk("bp_int0", rsp_int, 64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 4; i++) begin
         cyc();
         smp(); chk("bp_vld", rsp_valid, 1'b1);
                chk("bp_int", rsp_int, 64'h0123_4567_89AB_CDEF);
                chk("bp_id", rsp_id, 2'd1);
                chk("bp_gnt_hold", gnt, 4'b0000);
      end
      cyc(); rsp_ready = 1'b1; req = 4'b0000;
      smp(); chk("bp_vld_acc", rsp_valid, 1'b1);
      cyc();
      smp(); chk("bp_vld_done", rsp_valid, 1'b0);
             chk("bp_gnt_done", gnt, 4'b0000);

      // Invalid result passes through.
      run_conv("inv", 4'b0001, 1'b1, 4'b0001, 2'd0, F0, 2'b01, 64'h8000_0000_0000_0000, 1'b1);

      // Reset while in WAIT, then a stray cv_done.
      cyc(); req = 4'b1000;
      smp(); chk("rw_gnt", gnt, 4'b1000);
      cyc(); req = 4'b0000;
      smp();
      cyc();
      smp(); chk("rw_start_low", cv_start, 1'b0);
      reset = 1'b0;
      #1;
      chk("rw_async_float", cv_float, 32'd0);
      chk("rw_async_id", rsp_id, 2'd0);
      chk("rw_async_vld", rsp_valid, 1'b0);
      cyc(); reset = 1'b1; cv_done = 1'b1; cv_int = 64'd5;
      smp(); chk("rw_stray_vld0", rsp_valid, 1'b0);
      cyc();
      smp(); chk("rw_stray_vld1", rsp_valid, 1'b0);
             chk("rw_stray_start", cv_start, 1'b0);
      cv_done = 1'b0;
      cv_int = 64'd0;
      run_conv("post_rst", 4'b0001, 1'b1, 4'b0001, 2'd0, F0, 2'b01, 64'd9, 1'b0);

      // Long WAIT with no completion.
      cyc(); req = 4'b0010;
      smp(); chk("to_gnt", gnt, 4'b0010);
      cyc(); req = 4'b0000;
      smp(); chk("to_start", cv_start, 1'b1);
      stray = 0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         smp(); if (rsp_valid !== 1'b0) stray++;
      end
      chk("to_quiet64", stray, 0);
`ifdef FP_CONV_ARB_TIMEOUT_EN
      cyc();
      smp(); chk("to_vld", rsp_valid, 1'b1);
             chk("to_inv", rsp_invalid, 1'b1);
             chk("to_int", rsp_int, 64'h8000_0000_0000_0000);
             chk("to_id", rsp_id, 2'd1);
`else
      for (int i = 0; i < 36; i++) begin
         cyc();
         smp(); if (rsp_valid !== 1'b0) stray++;
      end
      chk("to_quiet100", stray, 0);
      cyc(); cv_done = 1'b1; cv_int = 64'd7;
      smp();
      cyc(); cv_done = 1'b0; cv_int = 64'd0;
      smp(); chk("late_vld", rsp_valid, 1'b1);
             chk("late_int", rsp_int, 64'd7);
             chk("late_inv", rsp_invalid, 1'b0);
             chk("late_id", rsp_id, 2'd1);
`endif
      cyc();
      smp(); chk("end_idle_vld", rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
